mton_sync_fifo: RTL and testbench
=================================

Name: mton_sync_fifo

Overview:
Single-clock, multi-port FIFO: up to M_WRITERS lanes push and up to N_READERS lanes pop in the same cycle.
- Accepted entries are kept in strict order: ascending lane index within a cycle, then cycle order.
- Same-clock successor of the M:1 async FIFO. Used where several producers and consumers share one clock domain and need per-lane acknowledge and valid, occupancy reporting and overflow/underflow flags.

Parameters:
WIDTH, 8, bits per entry
DEPTH, 4, log2 of entry count (2**DEPTH entries)
M_WRITERS, 4, write lanes (1..2**DEPTH)
N_READERS, 2, read lanes (1..2**DEPTH)
PFULL_TH, 12, programmable-full threshold (count >= TH)
PEMPTY_TH, 4, programmable-empty threshold (count <= TH)

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_wr_en  in  M_WRITERS  per-lane write request
i_wr_data  in  M_WRITERS*WIDTH  lane w at [w*WIDTH +: WIDTH]
o_wr_ack  out  M_WRITERS  combinational; lane accepted this cycle
i_rd_en  in  N_READERS  per-lane read request
o_rd_data  out  N_READERS*WIDTH  registered read data, lane r at [r*WIDTH +: WIDTH]
o_rd_valid  out  N_READERS  registered; lane data valid
o_count  out  DEPTH+1  current occupancy
o_full, o_afull, o_pfull  out  1 each  status flags
o_empty, o_aempty, o_pempty  out  1 each  status flags
o_ovf, o_udf  out  1 each  one-cycle error pulses

Behaviour:
- Reset (async assert, sync-released internally by the system): count=0, rd/wr pointers=0, o_rd_valid=0, o_rd_data=0, o_ovf=o_udf=0, o_empty=1, o_aempty=1, o_pempty=1, o_full=0, o_pfull=0, o_afull=(M_WRITERS>2**DEPTH ? 1 : 0). o_wr_ack forced 0 while i_rstn low.
- Free slots: free = 2**DEPTH - count, using the registered count at the start of the cycle.
- Write acceptance: enabled lanes are ranked by ascending index. A lane is acked iff its rank < free, so acceptance is partial, lowest lanes first. Acked lanes are written at wr_ptr+rank.
- Read service: enabled lanes are ranked by ascending index. A lane is served iff its rank < count (registered). Lane r gets mem[rd_ptr+rank].
- Read latency: o_rd_data and o_rd_valid update on the next edge. o_rd_valid=0 for unserved lanes; data on unserved lanes holds its previous value.
- Pointer and count update: wr_ptr += acked writes; rd_ptr += served reads; both are DEPTH-bit and wrap modulo 2**DEPTH. count_next = count + acked - served, with no saturation needed.
- Simultaneous push/pop: a slot freed in this cycle is not writable until the next cycle. An entry written in this cycle is not readable until the next cycle, so there is no bypass path.
- Flags: all registered, computed from count_next.
  - full = (count==2**DEPTH); afull = (free < M_WRITERS); pfull = (count >= PFULL_TH).
  - empty = (count==0); aempty = (count < N_READERS); pempty = (count <= PEMPTY_TH).
- o_ovf: asserts the cycle after any enabled write lane is not acked.
- o_udf: asserts the cycle after any enabled read lane is not served.
- Reset mid-operation: contents are discarded, every output returns to its reset value immediately, and in-flight o_rd_valid is cleared.
- Elaboration checks: PFULL_TH <= 2**DEPTH; PEMPTY_TH < 2**DEPTH; M_WRITERS and N_READERS within 1..2**DEPTH.

Decomposition:
- Package mton_fifo_pkg holds:
  - function popcount(vector) -> DEPTH+1 bits;
  - function lane_rank(vector, idx) = popcount of the enabled bits below idx;
  - typedef for the count type.
- Sub-module mton_lane_prefix (parameter LANES): takes an enable vector and a limit; outputs per-lane rank, a grant vector and the grant count. It is instantiated twice: writes (limit=free) and reads (limit=count).
- Storage is a flat 2**DEPTH x WIDTH register array inside the top module.

Test Plan:
(Defaults used throughout: WIDTH=8, DEPTH=4, M=4, N=2, PFULL_TH=12, PEMPTY_TH=4.)
- Reset release -> count=0, empty=aempty=pempty=1, full=afull=pfull=0, rd_valid=00, ovf=udf=0.
- wr_en=1011, lanes 0..3 = 0x11,0x22,0x33,0x44 -> ack=1011, count=3. Then rd_en=11 -> next cycle rd_valid=11, lane0=0x11, lane1=0x22. Then rd_en=10 -> lane1=0x44, rd_valid=10, empty=1.
- Fill to count=14, wr_en=1111 -> ack=0011, count=16, full=1, afull=1, ovf pulses exactly one cycle.
- At count=16, wr_en=1111 with rd_en=11 -> ack=0000, two reads served, count=14, ovf=1 for one cycle, full=0.
- Random push/pop for 2000 cycles against a scoreboard -> order matches, pointers wrap >50 times, count never exceeds 16, and flags agree with the model every cycle.
- At count=9, drop i_rstn mid-cycle -> outputs return to reset values immediately. After release, rd_en=01 -> rd_valid=00 and udf pulse.

Source files
------------

// File: rtl/mton_fifo_pkg.sv
// Shared helpers for the multi-port synchronous FIFO.
// Lane counting functions used by the per-lane prefix logic.
package mton_fifo_pkg;

    localparam int MAX_LANES = 256;

    // Wide enough to count any lane vector up to MAX_LANES.
    typedef logic [8:0] count_t;
    typedef logic [MAX_LANES-1:0] lane_vec_t;

    function automatic count_t popcount(input lane_vec_t v);
        count_t c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            c = c + count_t'(v[i]);
        end
        return c;
    endfunction

    function automatic count_t lane_rank(input lane_vec_t v, input int idx);
        lane_vec_t below;
        below = v & ((lane_vec_t'(1) << idx) - lane_vec_t'(1));
        return popcount(below);
    endfunction

endpackage

// File: rtl/mton_lane_prefix.sv
// Ranks enabled lanes by ascending index and grants those whose
// rank falls below the limit (free slots or stored entries).
module mton_lane_prefix
    import mton_fifo_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CW    = 5
) (
    input  logic [LANES-1:0]    en,
    input  logic [CW-1:0]       limit,
    output logic [LANES*CW-1:0] rank,
    output logic [LANES-1:0]    grant,
    output logic [CW-1:0]       total
);

    lane_vec_t vec;

    always_comb begin
        vec   = '0;
        rank  = '0;
        grant = '0;
        total = '0;
        vec[LANES-1:0] = en;
        for (int i = 0; i < LANES; i++) begin
            rank[i*CW +: CW] = CW'(lane_rank(vec, i));
            grant[i] = en[i] && (rank[i*CW +: CW] < limit);
            total = total + CW'(grant[i]);
        end
    end

endmodule

// File: rtl/mton_sync_fifo.sv
// Single-clock FIFO with M write lanes and N read lanes per cycle.
// Order is lane index within a cycle, then cycle order; no bypass.
module mton_sync_fifo
    import mton_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int M_WRITERS = 4,
    parameter int N_READERS = 2,
    parameter int PFULL_TH  = 12,
    parameter int PEMPTY_TH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic [M_WRITERS-1:0]       i_wr_en,
    input  logic [M_WRITERS*WIDTH-1:0] i_wr_data,
    output logic [M_WRITERS-1:0]       o_wr_ack,
    input  logic [N_READERS-1:0]       i_rd_en,
    output logic [N_READERS*WIDTH-1:0] o_rd_data,
    output logic [N_READERS-1:0]       o_rd_valid,
    output logic [DEPTH:0]             o_count,
    output logic                       o_full,
    output logic                       o_afull,
    output logic                       o_pfull,
    output logic                       o_empty,
    output logic                       o_aempty,
    output logic                       o_pempty,
    output logic                       o_ovf,
    output logic                       o_udf
);

    localparam int SLOTS = 2 ** DEPTH;
    localparam int CW    = DEPTH + 1;

    if (PFULL_TH > SLOTS || PEMPTY_TH >= SLOTS) begin : g_bad_th
        $error("mton_sync_fifo: threshold out of range");
    end
    if (M_WRITERS < 1 || M_WRITERS > SLOTS ||
        N_READERS < 1 || N_READERS > SLOTS) begin : g_bad_lanes
        $error("mton_sync_fifo: lane count out of range");
    end

    logic [WIDTH-1:0] mem [SLOTS];
    logic [DEPTH-1:0] wr_ptr;
    logic [DEPTH-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    free;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    free_next;

    logic [M_WRITERS*CW-1:0] wr_rank;
    logic [M_WRITERS-1:0]    wr_grant;
    logic [CW-1:0]           wr_total;
    logic [N_READERS*CW-1:0] rd_rank;
    logic [N_READERS-1:0]    rd_grant;
    logic [CW-1:0]           rd_total;

    assign free = CW'(SLOTS) - count;

    mton_lane_prefix #(
        .LANES (M_WRITERS),
        .CW    (CW)
    ) u_wr_prefix (
        .en    (i_wr_en),
        .limit (free),
        .rank  (wr_rank),
        .grant (wr_grant),
        .total (wr_total)
    );

    mton_lane_prefix #(
        .LANES (N_READERS),
        .CW    (CW)
    ) u_rd_prefix (
        .en    (i_rd_en),
        .limit (count),
        .rank  (rd_rank),
        .grant (rd_grant),
        .total (rd_total)
    );

    assign o_wr_ack   = wr_grant & {M_WRITERS{i_rstn}};
    assign count_next = count + wr_total - rd_total;
    assign free_next  = CW'(SLOTS) - count_next;
    assign o_count    = count;

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge i_clk) begin
        for (int w = 0; w < M_WRITERS; w++) begin
            if (wr_grant[w]) begin
                mem[DEPTH'({1'b0, wr_ptr} + wr_rank[w*CW +: CW])] <=
                    i_wr_data[w*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= '0;
            o_full     <= 1'b0;
            o_afull    <= (M_WRITERS > SLOTS);
            o_pfull    <= 1'b0;
            o_empty    <= 1'b1;
            o_aempty   <= 1'b1;
            o_pempty   <= 1'b1;
            o_ovf      <= 1'b0;
            o_udf      <= 1'b0;
        end else begin
            for (int r = 0; r < N_READERS; r++) begin
                if (rd_grant[r]) begin
                    o_rd_data[r*WIDTH +: WIDTH] <=
                        mem[DEPTH'({1'b0, rd_ptr} + rd_rank[r*CW +: CW])];
                end
            end
            o_rd_valid <= rd_grant;
            wr_ptr     <= DEPTH'({1'b0, wr_ptr} + wr_total);
            rd_ptr     <= DEPTH'({1'b0, rd_ptr} + rd_total);
            count      <= count_next;
            o_full     <= (count_next == CW'(SLOTS));
            o_afull    <= (free_next < CW'(M_WRITERS));
            o_pfull    <= (count_next >= CW'(PFULL_TH));
            o_empty    <= (count_next == '0);
            o_aempty   <= (count_next < CW'(N_READERS));
            o_pempty   <= (count_next <= CW'(PEMPTY_TH));
            o_ovf      <= |(i_wr_en & ~wr_grant);
            o_udf      <= |(i_rd_en & ~rd_grant);
        end
    end

endmodule

// File: tb/tb_mton_sync_fifo.sv
// Randomized bench for mton_sync_fifo against a queue-based model,
// plus directed sequences with literal expectations.
module tb_mton_sync_fifo;

    localparam int W     = 8;
    localparam int D     = 4;
    localparam int M     = 4;
    localparam int N     = 2;
    localparam int SLOTS = 16;

    logic           i_clk = 1'b0;
    logic           i_rstn = 1'b0;
    logic [M-1:0]   i_wr_en = '0;
    logic [M*W-1:0] i_wr_data = '0;
    logic [M-1:0]   o_wr_ack;
    logic [N-1:0]   i_rd_en = '0;
    logic [N*W-1:0] o_rd_data;
    logic [N-1:0]   o_rd_valid;
    logic [D:0]     o_count;
    logic o_full, o_afull, o_pfull, o_empty, o_aempty, o_pempty, o_ovf, o_udf;

    always #5 i_clk = ~i_clk;

    mton_sync_fifo #(
        .WIDTH(W), .DEPTH(D), .M_WRITERS(M), .N_READERS(N),
        .PFULL_TH(12), .PEMPTY_TH(4)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .o_wr_ack(o_wr_ack),
        .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_count(o_count),
        .o_full(o_full), .o_afull(o_afull), .o_pfull(o_pfull),
        .o_empty(o_empty), .o_aempty(o_aempty), .o_pempty(o_pempty),
        .o_ovf(o_ovf), .o_udf(o_udf)
    );

    logic [7:0]     q[$];
    logic [N-1:0]   e_valid;
    logic [N*W-1:0] e_data;
    logic           e_ovf, e_udf;
    logic [M-1:0]   seen_ack;
    int             pushes = 0;
    int             max_cnt = 0;
    int             checks = 0;
    int             errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [M-1:0] model_ack();
        logic [M-1:0] a;
        int rk;
        int fr;
        a  = '0;
        rk = 0;
        fr = SLOTS - q.size();
        for (int w = 0; w < M; w++) begin
            if (i_wr_en[w]) begin
                if (rk < fr) a[w] = 1'b1;
                rk++;
            end
        end
        return i_rstn ? a : '0;
    endfunction

    task automatic model_reset();
        q.delete();
        e_valid = '0;
        e_data  = '0;
        e_ovf   = 1'b0;
        e_udf   = 1'b0;
    endtask

    task automatic model_step();
        int sz;
        int fr;
        int rk;
        sz    = q.size();
        fr    = SLOTS - sz;
        e_ovf = 1'b0;
        e_udf = 1'b0;
        rk    = 0;
        for (int r = 0; r < N; r++) begin
            e_valid[r] = 1'b0;
            if (i_rd_en[r]) begin
                if (rk < sz) begin
                    e_data[r*W +: W] = q.pop_front();
                    e_valid[r] = 1'b1;
                end else begin
                    e_udf = 1'b1;
                end
                rk++;
            end
        end
        rk = 0;
        for (int w = 0; w < M; w++) begin
            if (i_wr_en[w]) begin
                if (rk < fr) begin
                    q.push_back(i_wr_data[w*W +: W]);
                    pushes++;
                end else begin
                    e_ovf = 1'b1;
                end
                rk++;
            end
        end
    endtask

    task automatic compare();
        int sz;
        sz = q.size();
        seen_ack = o_wr_ack;
        if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
        chk("wr_ack", 32'(o_wr_ack), 32'(model_ack()));
        chk("count", 32'(o_count), 32'(sz));
        chk("full", 32'(o_full), 32'(sz == SLOTS));
        chk("afull", 32'(o_afull), 32'((SLOTS - sz) < M));
        chk("pfull", 32'(o_pfull), 32'(sz >= 12));
        chk("empty", 32'(o_empty), 32'(sz == 0));
        chk("aempty", 32'(o_aempty), 32'(sz < N));
        chk("pempty", 32'(o_pempty), 32'(sz <= 4));
        chk("rd_valid", 32'(o_rd_valid), 32'(e_valid));
        chk("rd_data", 32'(o_rd_data), 32'(e_data));
        chk("ovf", 32'(o_ovf), 32'(e_ovf));
        chk("udf", 32'(o_udf), 32'(e_udf));
    endtask

    task automatic step(input logic [M-1:0] we, input logic [M*W-1:0] wd,
                        input logic [N-1:0] re);
        i_wr_en   = we;
        i_wr_data = wd;
        i_rd_en   = re;
        @(negedge i_clk);
        compare();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int pw;
        int pr;
        logic [M-1:0] we;
        logic [N-1:0] re;
        model_reset();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        chk("rst_count", 32'(o_count), 0);
        chk("rst_empty", 32'({o_empty, o_aempty, o_pempty}), 32'h7);
        chk("rst_fullflags", 32'({o_full, o_afull, o_pfull}), 0);
        chk("rst_valid", 32'(o_rd_valid), 0);
        chk("rst_err", 32'({o_ovf, o_udf}), 0);

        step(4'b1011, 32'h44_33_22_11, 2'b00);
        chk("lit_ack_1011", 32'(seen_ack), 32'b1011);
        chk("lit_count3", 32'(o_count), 3);
        step('0, '0, 2'b11);
        chk("lit_valid11", 32'(o_rd_valid), 32'b11);
        chk("lit_data_11_22", 32'(o_rd_data), 32'h2211);
        step('0, '0, 2'b10);
        chk("lit_valid10", 32'(o_rd_valid), 32'b10);
        chk("lit_lane1_44", 32'(o_rd_data[W +: W]), 32'h44);
        chk("lit_empty", 32'(o_empty), 1);

        repeat (3) step(4'b1111, 32'($urandom), 2'b00);
        step(4'b0011, 32'($urandom), 2'b00);
        chk("lit_count14", 32'(o_count), 14);
        step(4'b1111, 32'($urandom), 2'b00);
        chk("lit_ack_0011", 32'(seen_ack), 32'b0011);
        chk("lit_count16", 32'(o_count), 16);
        chk("lit_full_afull", 32'({o_full, o_afull}), 32'b11);
        chk("lit_ovf_hi", 32'(o_ovf), 1);
        step('0, '0, 2'b00);
        chk("lit_ovf_lo", 32'(o_ovf), 0);
        step(4'b1111, 32'($urandom), 2'b11);
        chk("lit_ack_0000", 32'(seen_ack), 0);
        chk("lit_count14b", 32'(o_count), 14);
        chk("lit_ovf_full", 32'({o_ovf, o_full}), 32'b10);
        chk("lit_valid_both", 32'(o_rd_valid), 32'b11);

        for (int c = 0; c < 2000; c++) begin
            case ((c / 150) % 3)
                0: begin pw = 45; pr = 90; end
                1: begin pw = 70; pr = 20; end
                default: begin pw = 15; pr = 90; end
            endcase
            for (int w = 0; w < M; w++) we[w] = ($urandom_range(99) < pw);
            for (int r = 0; r < N; r++) re[r] = ($urandom_range(99) < pr);
            step(we, 32'($urandom), re);
        end
        chk("ptr_wraps_gt50", 32'((pushes / SLOTS) > 50), 1);
        chk("count_le16", 32'(max_cnt <= SLOTS), 1);

        for (int k = 0; k < 20; k++) begin
            if (q.size() != 0) step('0, '0, 2'b11);
        end
        step(4'b1111, 32'($urandom), 2'b00);
        step(4'b1111, 32'($urandom), 2'b00);
        step(4'b0111, 32'($urandom), 2'b00);
        step('0, '0, 2'b11);
        chk("lit_count9", 32'(o_count), 9);
        chk("lit_inflight_valid", 32'(o_rd_valid), 32'b11);

        #2;
        i_wr_en = 4'b1111;
        i_rd_en = 2'b11;
        i_rstn  = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_count", 32'(o_count), 0);
        chk("mid_rst_valid", 32'(o_rd_valid), 0);
        chk("mid_rst_data", 32'(o_rd_data), 0);
        chk("mid_rst_ack", 32'(o_wr_ack), 0);
        chk("mid_rst_flags", 32'({o_empty, o_aempty, o_pempty,
                                  o_full, o_afull, o_pfull}), 32'b111000);
        compare();
        @(negedge i_clk);
        compare();
        i_wr_en = '0;
        i_rd_en = '0;
        i_rstn  = 1'b1;
        @(posedge i_clk);
        #1;
        step('0, '0, 2'b01);
        chk("post_rst_valid", 32'(o_rd_valid), 0);
        chk("post_rst_udf", 32'(o_udf), 1);
        step('0, '0, 2'b00);
        chk("post_rst_udf_lo", 32'(o_udf), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
